// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types and encodings for the ID-stage hazard/forwarding controller.
package id_hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned FWD_WIDTH      = 2;

  // Operand source selects for the ID-stage forward muxes
  localparam logic [FWD_WIDTH-1:0] FWD_REG = 2'b00;
  localparam logic [FWD_WIDTH-1:0] FWD_ALU = 2'b01;
  localparam logic [FWD_WIDTH-1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // One in-flight writer tracked per downstream stage
  typedef struct packed {
    logic                      v;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      wr;
    logic                      ld;
  } sb_slot_t;

  // x0 is hardwired to zero, so it never matches a writer
  function automatic logic slot_hit(input sb_slot_t s, input logic use_rs,
                                    input logic [REG_ADDR_WIDTH-1:0] rs);
    return use_rs & s.v & s.wr & (s.rd == rs) & (rs != '0);
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Three-slot EX/MEM/WB writer tracker with per-operand hazard and forward-select resolution.
module id_scoreboard
  import id_hazard_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_wr_en,
  input  logic                      id_is_load,
  input  logic                      id_ex_bubble,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  output logic                      haz_rs1,
  output logic                      haz_rs2,
  output logic [FWD_WIDTH-1:0]      fwd_rs1,
  output logic [FWD_WIDTH-1:0]      fwd_rs2,
  output logic                      any_valid
);

  sb_slot_t ex_q, mem_q, wb_q;
  sb_slot_t ex_d, mem_d, wb_d;

  // Youngest writer wins: {hazard, select}
  function automatic logic [FWD_WIDTH:0] resolve(
    input sb_slot_t ex, input sb_slot_t mem, input sb_slot_t wb,
    input logic use_rs, input logic [REG_ADDR_WIDTH-1:0] rs);
    logic [FWD_WIDTH:0] r;
    r = {1'b0, FWD_REG};
    if (slot_hit(ex, use_rs, rs))       r = {1'b1, FWD_REG};
    else if (slot_hit(mem, use_rs, rs)) r = mem.ld ? {1'b1, FWD_REG} : {1'b0, FWD_ALU};
    else if (slot_hit(wb, use_rs, rs))  r = {1'b0, FWD_MEM};
    return r;
  endfunction

  // Shift the pipeline shadow one stage; a bubble enters EX as an invalid slot
  always_comb begin
    ex_d    = '0;
    ex_d.v  = id_valid & id_reg_wr_en & ~id_ex_bubble;
    ex_d.rd = id_rd;
    ex_d.wr = id_reg_wr_en;
    ex_d.ld = id_is_load;
    mem_d   = ex_q;
    wb_d    = mem_q;
  end

  // Slot registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Per-operand resolution, same cycle as the ID read
  always_comb begin
    {haz_rs1, fwd_rs1} = resolve(ex_q, mem_q, wb_q, id_use_rs1, id_rs1);
    {haz_rs2, fwd_rs2} = resolve(ex_q, mem_q, wb_q, id_use_rs2, id_rs2);
    any_valid          = ex_q.v | mem_q.v | wb_q.v;
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: RUN/STALL/HALT sequencing, forward selects and perf counters.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_wr_en,
  input  logic                      id_is_load,
  input  logic                      pc_sel,
  input  logic                      halt_req,
  output logic [FWD_WIDTH-1:0]      forward_comp1,
  output logic [FWD_WIDTH-1:0]      forward_comp2,
  output logic                      pc_write_en,
  output logic                      if_id_write_en,
  output logic                      if_id_flush,
  output logic                      id_ex_bubble,
  output logic                      halted,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                 haz_rs1, haz_rs2, haz, any_valid;
  logic                 stall_inc, flush_inc;

  id_scoreboard u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rd        (id_rd),
    .id_reg_wr_en (id_reg_wr_en),
    .id_is_load   (id_is_load),
    .id_ex_bubble (id_ex_bubble),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .haz_rs1      (haz_rs1),
    .haz_rs2      (haz_rs2),
    .fwd_rs1      (forward_comp1),
    .fwd_rs2      (forward_comp2),
    .any_valid    (any_valid)
  );

  assign haz = id_valid & (haz_rs1 | haz_rs2);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state: halt request outranks a data hazard
  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (halt_req) state_d = ST_HALT;
        else if (haz) state_d = ST_STALL;
        else          state_d = ST_RUN;
      end
      ST_HALT: state_d = halt_req ? ST_HALT : ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Pipeline controls; a taken branch is ignored while its operands are still pending
  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    halted         = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (halt_req || haz) begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          id_ex_bubble   = 1'b1;
          stall_inc      = ~halt_req;
        end else if (pc_sel && id_valid) begin
          if_id_flush = 1'b1;
          flush_inc   = 1'b1;
        end
      end
      ST_HALT: begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_bubble   = 1'b1;
        halted         = ~any_valid;
      end
      default: ;
    endcase
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl; a 2-bit-counter twin shares all inputs to reach saturation.
module tb_id_hazard_ctrl;
  import id_hazard_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_wr_en, id_is_load, pc_sel, halt_req;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic [1:0]  fc1, fc2, s_fc1, s_fc2;
  logic        pc_we, ifid_we, ifid_fl, bub, hlt;
  logic        s_pc_we, s_ifid_we, s_ifid_fl, s_bub, s_hlt;
  logic [31:0] stall_cnt, flush_cnt;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_wr_en(id_reg_wr_en), .id_is_load(id_is_load), .pc_sel(pc_sel), .halt_req(halt_req),
    .forward_comp1(fc1), .forward_comp2(fc2), .pc_write_en(pc_we), .if_id_write_en(ifid_we),
    .if_id_flush(ifid_fl), .id_ex_bubble(bub), .halted(hlt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_hazard_ctrl #(.CNT_WIDTH(2)) dut_small (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_wr_en(id_reg_wr_en), .id_is_load(id_is_load), .pc_sel(pc_sel), .halt_req(halt_req),
    .forward_comp1(s_fc1), .forward_comp2(s_fc2), .pc_write_en(s_pc_we), .if_id_write_en(s_ifid_we),
    .if_id_flush(s_ifid_fl), .id_ex_bubble(s_bub), .halted(s_hlt),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control group {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, halted}
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, 32'({pc_we, ifid_we, ifid_fl, bub, hlt}), 32'(exp));
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] e1, input logic [1:0] e2);
    chk(tag, 32'({fc1, fc2}), 32'({e1, e2}));
  endtask

  task automatic instr(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic ld, input logic ps);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_wr_en = wr; id_is_load = ld; pc_sel = ps;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  localparam logic [4:0] CTL_RUN    = 5'b11000;
  localparam logic [4:0] CTL_FREEZE = 5'b00010;
  localparam logic [4:0] CTL_FLUSH  = 5'b11100;
  localparam logic [4:0] CTL_HALTED = 5'b00011;

  initial begin
    reset = 1'b1; halt_req = 1'b0;
    instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick; tick;
    chk_ctl("reset_ctl", CTL_RUN);
    chk_fwd("reset_fwd", FWD_REG, FWD_REG);
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    chk("reset_flush_cnt", flush_cnt, 32'd0);
    reset = 1'b0;

    // add x5,x1,x2 ; add x6,x5,x1
    instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    chk_ctl("alu_producer_ctl", CTL_RUN);
    tick;
    instr(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    chk_ctl("alu_dep_stall", CTL_FREEZE);
    tick;
    chk_ctl("alu_dep_resume", CTL_RUN);
    chk_fwd("alu_dep_fwd", FWD_ALU, FWD_REG);
    chk("alu_dep_stall_cnt", stall_cnt, 32'd1);
    tick;

    // lw x5,0(x1) ; add x6,x1,x5
    instr(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    chk_ctl("load_issue_ctl", CTL_RUN);
    tick;
    instr(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    chk_ctl("load_use_stall1", CTL_FREEZE);
    tick;
    chk_ctl("load_use_stall2", CTL_FREEZE);
    tick;
    chk_ctl("load_use_resume", CTL_RUN);
    chk_fwd("load_use_fwd", FWD_REG, FWD_MEM);
    chk("load_use_stall_cnt", stall_cnt, 32'd3);
    tick;

    // add x0,x1,x2 ; add x7,x0,x0
    instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    chk_ctl("x0_write_ctl", CTL_RUN);
    tick;
    instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    chk_ctl("x0_read_ctl", CTL_RUN);
    chk_fwd("x0_read_fwd", FWD_REG, FWD_REG);
    tick;

    // add x5,x1,x2 ; beq x5,x5 taken
    instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick;
    instr(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    chk_ctl("branch_stall_no_flush", CTL_FREEZE);
    tick;
    chk("branch_stall_flush_cnt", flush_cnt, 32'd0);
    chk_ctl("branch_flush", CTL_FLUSH);
    chk_fwd("branch_fwd", FWD_ALU, FWD_ALU);
    tick;
    chk("branch_flush_cnt", flush_cnt, 32'd1);
    chk("branch_stall_cnt", stall_cnt, 32'd4);
    chk("small_stall_sat", 32'(s_stall_cnt), 32'd3);

    // pc_sel without a valid instruction does not flush
    instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk_ctl("invalid_pc_sel_ctl", CTL_RUN);
    tick;
    chk("invalid_pc_sel_cnt", flush_cnt, 32'd1);

    // Three writers in flight, then halt
    for (int i = 0; i < 3; i++) begin
      instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'(8 + i), 1'b1, 1'b0, 1'b0);
      tick;
    end
    instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    halt_req = 1'b1;
    #1;
    chk_ctl("halt_req_bubble", CTL_FREEZE);
    tick;
    chk_ctl("halt_drain1", CTL_FREEZE);
    tick;
    chk_ctl("halt_drain2", CTL_FREEZE);
    tick;
    chk_ctl("halted", CTL_HALTED);
    tick;
    chk_ctl("halted_hold", CTL_HALTED);
    halt_req = 1'b0;
    #1;
    chk_ctl("halt_release_cycle", CTL_HALTED);
    tick;
    chk_ctl("halt_resume_run", CTL_RUN);
    chk("halt_no_stall_count", stall_cnt, 32'd4);
    tick;

    // Four taken branches saturate the 2-bit flush counter
    for (int i = 0; i < 4; i++) begin
      instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      tick;
    end
    chk("flush_cnt_loop", flush_cnt, 32'd5);
    chk("small_flush_sat", 32'(s_flush_cnt), 32'd3);

    // lw x5 ; add x6,x5,x1 then reset while in STALL
    instr(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick;
    instr(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    chk_ctl("pre_reset_stall", CTL_FREEZE);
    tick;
    chk("pre_reset_stall_cnt", stall_cnt, 32'd5);
    chk("small_stall_sat_hold", 32'(s_stall_cnt), 32'd3);
    chk_ctl("stall_state_ctl", CTL_FREEZE);
    reset = 1'b1;
    tick;
    chk_ctl("reset_in_stall_ctl", CTL_RUN);
    chk_fwd("reset_in_stall_fwd", FWD_REG, FWD_REG);
    chk("reset_in_stall_stall_cnt", stall_cnt, 32'd0);
    chk("reset_in_stall_flush_cnt", flush_cnt, 32'd0);
    reset = 1'b0;
    instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick;
    chk_ctl("post_reset_run", CTL_RUN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
